// File: rtl/accelerator_integration_pkg.sv
// Shared types and constants for the pipelined fixed-point vector integrator.
package accelerator_integration_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic RECTANGLE_MODE = 1'b0;
  localparam logic TRAPEZOID_MODE = 1'b1;

  localparam int unsigned ZERO = 0;
  localparam int unsigned ONE  = 1;

endpackage

// File: rtl/accelerator_vector_integration_pipelined_if.sv
// Control/data bundle between the NTM controller datapath and the vector integrator.
interface accelerator_vector_integration_pipelined_if #(
  parameter int DATA_SIZE = 64
);

  logic                 START;
  logic                 READY;
  logic                 MODE_IN;
  logic                 DATA_IN_ENABLE;
  logic                 DATA_OUT_VECTOR_ENABLE;
  logic                 DATA_OUT_SCALAR_ENABLE;
  logic                 OVERFLOW;
  logic [DATA_SIZE-1:0] SIZE_IN;
  logic [DATA_SIZE-1:0] PERIOD_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START, MODE_IN, DATA_IN_ENABLE, SIZE_IN, PERIOD_IN, DATA_IN,
    input  READY, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, OVERFLOW, DATA_OUT
  );

  modport slave (
    input  START, MODE_IN, DATA_IN_ENABLE, SIZE_IN, PERIOD_IN, DATA_IN,
    output READY, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, OVERFLOW, DATA_OUT
  );

endinterface

// File: rtl/accelerator_integration_mac.sv
// Combinational slice multiply: rectangle x*dt or trapezoid (a+b)*dt/2, rescaled to the
// fixed-point format. ACCELERATOR_INTEGRATION_SATURATE_EN clamps an out-of-range slice.
module accelerator_integration_mac
  import accelerator_integration_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic signed [DATA_SIZE-1:0] a_i,
  input  logic signed [DATA_SIZE-1:0] b_i,
  input  logic signed [DATA_SIZE-1:0] dt_i,
  input  logic                        mode_i,
  output logic signed [DATA_SIZE-1:0] p_o,
  output logic                        ovf_o
);

  localparam int W = 2 * DATA_SIZE + 1;

  logic signed [DATA_SIZE:0] sum;
  logic signed [W-1:0]       prod;
  logic signed [W-1:0]       shifted;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sum     = '0;
    prod    = '0;
    shifted = '0;
    p_o     = '0;
    ovf_o   = 1'b0;
    if (mode_i == RECTANGLE_MODE) begin
      prod    = W'(b_i) * W'(dt_i);
      shifted = prod >>> FRACTION_SIZE;
    end else begin
      // The extra sum bit keeps x[i-1]+x[i] exact; the extra shift is the divide by two.
      sum     = (DATA_SIZE + 1)'(a_i) + (DATA_SIZE + 1)'(b_i);
      prod    = W'(sum) * W'(dt_i);
      shifted = prod >>> (FRACTION_SIZE + 1);
    end
    p_o   = shifted[DATA_SIZE-1:0];
    ovf_o = (shifted != W'(p_o));
`ifdef ACCELERATOR_INTEGRATION_SATURATE_EN
    if (ovf_o) begin
      p_o = shifted[W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/accelerator_vector_integration_pipelined.sv
// Two-stage streaming fixed-point integrator (multiply, then accumulate), one sample per cycle.
// Define ACCELERATOR_INTEGRATION_SATURATE_EN to clamp the accumulator instead of wrapping.
module accelerator_vector_integration_pipelined
  import accelerator_integration_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int CONTROL_SIZE  = 4
) (
  input logic CLK,
  input logic RST,
  accelerator_vector_integration_pipelined_if.slave bus
);

  if (FRACTION_SIZE >= DATA_SIZE || CONTROL_SIZE < 1) begin : g_bad_cfg
    $error("accelerator_vector_integration_pipelined: invalid parameter set");
  end

  localparam int D = DATA_SIZE;

  state_e         state_q;
  logic [D-1:0]   size_q, period_q, count_q, prev_q, acc_q;
  logic           mode_q;
  logic [D-1:0]   s1_p_q;
  logic           s1_valid_q, s1_last_q, s1_pov_q;
  logic [D-1:0]   data_out_q;
  logic           vec_en_q, sc_en_q, ready_q, ovf_q;

  logic           accept, last;
  logic [D-1:0]   mac_p;
  logic           mac_ovf;
  logic [D-1:0]   sum_d, acc_d;
  logic           add_ovf;

  assign accept = (state_q == RUN) && bus.DATA_IN_ENABLE && (count_q < size_q);
  assign last   = accept && (count_q == size_q - D'(ONE));

  accelerator_integration_mac #(
    .DATA_SIZE     (DATA_SIZE),
    .FRACTION_SIZE (FRACTION_SIZE)
  ) u_mac (
    .a_i    (prev_q),
    .b_i    (bus.DATA_IN),
    .dt_i   (period_q),
    .mode_i (mode_q),
    .p_o    (mac_p),
    .ovf_o  (mac_ovf)
  );

  always_comb begin
    sum_d   = acc_q + s1_p_q;
    add_ovf = (acc_q[D-1] == s1_p_q[D-1]) && (sum_d[D-1] != acc_q[D-1]);
    acc_d   = sum_d;
`ifdef ACCELERATOR_INTEGRATION_SATURATE_EN
    if (add_ovf) begin
      acc_d = acc_q[D-1] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      size_q     <= D'(ZERO);
      period_q   <= D'(ZERO);
      count_q    <= D'(ZERO);
      prev_q     <= D'(ZERO);
      acc_q      <= D'(ZERO);
      mode_q     <= RECTANGLE_MODE;
      s1_p_q     <= D'(ZERO);
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pov_q   <= 1'b0;
      data_out_q <= D'(ZERO);
      vec_en_q   <= 1'b0;
      sc_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vec_en_q   <= 1'b0;
      sc_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      s1_valid_q <= accept;
      s1_last_q  <= last;

      if (accept) begin
        count_q <= count_q + D'(ONE);
        prev_q  <= bus.DATA_IN;
        // The first trapezoid sample only primes x[i-1].
        if (mode_q == TRAPEZOID_MODE && count_q == D'(ZERO)) begin
          s1_p_q   <= D'(ZERO);
          s1_pov_q <= 1'b0;
        end else begin
          s1_p_q   <= mac_p;
          s1_pov_q <= mac_ovf;
        end
      end

      if (s1_valid_q) begin
        acc_q      <= acc_d;
        data_out_q <= acc_d;
        vec_en_q   <= 1'b1;
        if (add_ovf || s1_pov_q) ovf_q <= 1'b1;
        if (s1_last_q) begin
          sc_en_q <= 1'b1;
          ready_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.START) begin
            size_q   <= bus.SIZE_IN;
            period_q <= bus.PERIOD_IN;
            mode_q   <= bus.MODE_IN;
            acc_q    <= D'(ZERO);
            count_q  <= D'(ZERO);
            prev_q   <= D'(ZERO);
            ovf_q    <= 1'b0;
            if (bus.SIZE_IN == D'(ZERO)) begin
              state_q    <= DONE;
              data_out_q <= D'(ZERO);
              sc_en_q    <= 1'b1;
              ready_q    <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (s1_valid_q && s1_last_q) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.DATA_OUT               = data_out_q;
  assign bus.DATA_OUT_VECTOR_ENABLE = vec_en_q;
  assign bus.DATA_OUT_SCALAR_ENABLE = sc_en_q;
  assign bus.READY                  = ready_q;
  assign bus.OVERFLOW               = ovf_q;

endmodule

// File: tb/tb_accelerator_vector_integration_pipelined.sv
// Directed bench for the vector integrator at DATA_SIZE=16, FRACTION_SIZE=8.
module tb_accelerator_vector_integration_pipelined;
  import accelerator_integration_pkg::*;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  accelerator_vector_integration_pipelined_if #(.DATA_SIZE(D)) bus ();

  accelerator_vector_integration_pipelined #(
    .DATA_SIZE     (D),
    .FRACTION_SIZE (8),
    .CONTROL_SIZE  (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled 1 time unit after each rising edge.
  logic [D-1:0] vq_data[$];
  int           vq_cyc[$];
  int           sc_cnt = 0;
  int           rdy_cnt = 0;
  int           sc_cyc = 0;
  logic [D-1:0] sc_data = '0;
  logic         sc_vec = 1'b0;
  logic         sc_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.DATA_OUT_VECTOR_ENABLE) begin
      vq_data.push_back(bus.DATA_OUT);
      vq_cyc.push_back(cyc);
    end
    if (bus.DATA_OUT_SCALAR_ENABLE) begin
      sc_cnt++;
      sc_cyc  = cyc;
      sc_data = bus.DATA_OUT;
      sc_vec  = bus.DATA_OUT_VECTOR_ENABLE;
      sc_rdy  = bus.READY;
    end
    if (bus.READY) rdy_cnt++;
  end

  logic [D-1:0] xs[8];
  logic [D-1:0] ev[8];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_vec(input logic [D-1:0] x0, x1, x2, e0, e1, e2);
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
  endtask

  task automatic run_vec(input string tag, input logic mode, input logic [D-1:0] dt,
                         input int n, input int gap, input logic [D-1:0] exp_final,
                         input logic exp_ovf, input bit extra);
    int bv, bs, br, s_cyc, w, got_n;
    int dq[$];
    bv = vq_data.size();
    bs = sc_cnt;
    br = rdy_cnt;
    bus.START     = 1'b1;
    bus.SIZE_IN   = D'(n);
    bus.PERIOD_IN = dt;
    bus.MODE_IN   = mode;
    s_cyc = cyc;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.DATA_IN        = xs[i];
      bus.DATA_IN_ENABLE = 1'b1;
      if (extra && i == 1) begin
        bus.START   = 1'b1;
        bus.SIZE_IN = 16'd7;
        bus.MODE_IN = ~mode;
      end
      dq.push_back(cyc);
      step();
      bus.DATA_IN_ENABLE = 1'b0;
      bus.START          = 1'b0;
      repeat (gap) step();
    end
    if (extra) begin
      repeat (2) begin
        bus.DATA_IN        = 16'h1000;
        bus.DATA_IN_ENABLE = 1'b1;
        step();
      end
      bus.DATA_IN_ENABLE = 1'b0;
    end
    w = 0;
    while (sc_cnt == bs && w < 20) begin
      step();
      w++;
    end
    check({tag, " scalar_count"}, sc_cnt - bs, 1);
    step();
    step();
    got_n = vq_data.size() - bv;
    check({tag, " vector_count"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++) begin
      check($sformatf("%s vec%0d", tag, i), vq_data[bv+i], ev[i]);
      check($sformatf("%s lat%0d", tag, i), vq_cyc[bv+i] - dq[i], 2);
    end
    check({tag, " final"}, sc_data, exp_final);
    check({tag, " ready_with_scalar"}, sc_rdy, 1'b1);
    check({tag, " vec_with_scalar"}, sc_vec, (n > 0));
    check({tag, " scalar_cycle"}, sc_cyc, (n > 0) ? dq[n-1] + 2 : s_cyc + 1);
    check({tag, " ready_count"}, rdy_cnt - br, 1);
    check({tag, " overflow"}, bus.OVERFLOW, exp_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  int rv, rr;

  initial begin
    bus.START          = 1'b0;
    bus.MODE_IN        = RECTANGLE_MODE;
    bus.DATA_IN_ENABLE = 1'b0;
    bus.SIZE_IN        = '0;
    bus.PERIOD_IN      = '0;
    bus.DATA_IN        = '0;
    rst = 1'b0;
    step();
    step();
    check("reset data_out", bus.DATA_OUT, 16'h0000);
    check("reset ready", bus.READY, 1'b0);
    check("reset overflow", bus.OVERFLOW, 1'b0);
    check("reset vec_en", bus.DATA_OUT_VECTOR_ENABLE, 1'b0);
    check("reset sc_en", bus.DATA_OUT_SCALAR_ENABLE, 1'b0);
    rst = 1'b1;
    step();

    set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0180, 16'h0300);
    run_vec("rect", RECTANGLE_MODE, 16'h0080, 3, 0, 16'h0300, 1'b0, 1'b0);

    set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0000, 16'h00C0, 16'h0200);
    run_vec("trap", TRAPEZOID_MODE, 16'h0080, 3, 0, 16'h0200, 1'b0, 1'b0);

`ifdef ACCELERATOR_INTEGRATION_SATURATE_EN
    set_vec(16'h7F00, 16'h7F00, 16'h0000, 16'h7F00, 16'h7FFF, 16'h0000);
    run_vec("ovf", RECTANGLE_MODE, 16'h0100, 2, 0, 16'h7FFF, 1'b1, 1'b0);
`else
    set_vec(16'h7F00, 16'h7F00, 16'h0000, 16'h7F00, 16'hFE00, 16'h0000);
    run_vec("ovf", RECTANGLE_MODE, 16'h0100, 2, 0, 16'hFE00, 1'b1, 1'b0);
`endif

    // START during RUN and enables beyond SIZE must be ignored; OVERFLOW clears on START.
    set_vec(16'h0100, 16'h0200, 16'h0000, 16'h0100, 16'h0300, 16'h0000);
    run_vec("ignore", RECTANGLE_MODE, 16'h0100, 2, 0, 16'h0300, 1'b0, 1'b1);

    run_vec("size0", RECTANGLE_MODE, 16'h0080, 0, 0, 16'h0000, 1'b0, 1'b0);

    set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0180, 16'h0300);
    run_vec("gapped", RECTANGLE_MODE, 16'h0080, 3, 2, 16'h0300, 1'b0, 1'b0);

    // Abort mid-vector with reset.
    rv = vq_data.size();
    rr = rdy_cnt;
    bus.START     = 1'b1;
    bus.SIZE_IN   = 16'd3;
    bus.PERIOD_IN = 16'h0080;
    bus.MODE_IN   = RECTANGLE_MODE;
    step();
    bus.START          = 1'b0;
    bus.DATA_IN        = 16'h0100;
    bus.DATA_IN_ENABLE = 1'b1;
    step();
    bus.DATA_IN_ENABLE = 1'b0;
    rst = 1'b0;
    step();
    check("abort data_out", bus.DATA_OUT, 16'h0000);
    check("abort vec_en", bus.DATA_OUT_VECTOR_ENABLE, 1'b0);
    check("abort sc_en", bus.DATA_OUT_SCALAR_ENABLE, 1'b0);
    check("abort ready", bus.READY, 1'b0);
    check("abort overflow", bus.OVERFLOW, 1'b0);
    rst = 1'b1;
    repeat (5) step();
    check("abort no_vector", vq_data.size() - rv, 0);
    check("abort no_ready", rdy_cnt - rr, 0);

    set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0180, 16'h0300);
    run_vec("after_rst", RECTANGLE_MODE, 16'h0080, 3, 0, 16'h0300, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
